// File: rtl/stopwatch_controller_if.sv
// Button/status bundle between the stopwatch front panel and its controller.
// The controller sits on the slave side.
interface stopwatch_controller_if;
  logic       start_stop;
  logic       lap;
  logic       clear;
  logic       at_max;
  logic       tick;
  logic       clear_count;
  logic       freeze_display;
  logic [1:0] state;

  modport master (
    output start_stop, lap, clear, at_max,
    input  tick, clear_count, freeze_display, state
  );

  modport slave (
    input  start_stop, lap, clear, at_max,
    output tick, clear_count, freeze_display, state
  );
endinterface

// File: rtl/stopwatch_controller.sv
// Stopwatch control FSM: button edge detection, run/pause/lap modes,
// and the prescaler that turns clk into count ticks for the digit counter.
module stopwatch_controller #(
  parameter int CLK_HZ  = 100000000,
  parameter int TICK_HZ = 100
) (
  input logic             clk,
  input logic             reset,
  stopwatch_controller_if.slave sw
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_t;

  state_t        st;
  state_t        nxt;
  logic [PW-1:0] presc;
  logic          start_stop_p0;
  logic          lap_p0;
  logic          clear_p0;
  logic          tick_r;
  logic          clear_count_r;
  logic          freeze_r;
  logic          clr_pulse;

  logic ss_ev;
  logic lap_ev;
  logic clr_ev;
  logic running;
  logic wrap;

  assign ss_ev   = sw.start_stop & ~start_stop_p0;
  assign lap_ev  = sw.lap & ~lap_p0;
  assign clr_ev  = sw.clear & ~clear_p0;
  assign running = (st == RUN) || (st == LAP);
  assign wrap    = running && (presc == LAST);

  // The highest-priority event that means something in the current state wins;
  // an overrun at the counter maximum overrides every button.
  always_comb begin
    nxt       = st;
    clr_pulse = 1'b0;
    case (st)
      IDLE: begin
        if (clr_ev)     clr_pulse = 1'b1;
        else if (ss_ev) nxt = RUN;
      end
      RUN: begin
        if (ss_ev)       nxt = PAUSE;
        else if (lap_ev) nxt = LAP;
      end
      LAP: begin
        if (ss_ev)       nxt = PAUSE;
        else if (lap_ev) nxt = RUN;
      end
      PAUSE: begin
        if (clr_ev) begin
          clr_pulse = 1'b1;
          nxt       = IDLE;
        end else if (ss_ev) begin
          nxt = RUN;
        end
      end
      default: nxt = IDLE;
    endcase
    if (wrap && sw.at_max) nxt = PAUSE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st            <= IDLE;
      presc         <= '0;
      start_stop_p0 <= 1'b0;
      lap_p0        <= 1'b0;
      clear_p0      <= 1'b0;
      tick_r        <= 1'b0;
      clear_count_r <= 1'b0;
      freeze_r      <= 1'b0;
    end else begin
      start_stop_p0 <= sw.start_stop;
      lap_p0        <= sw.lap;
      clear_p0      <= sw.clear;
      st            <= nxt;
      freeze_r      <= (nxt == LAP);
      tick_r        <= wrap && !sw.at_max;
      clear_count_r <= clr_pulse;
      if (clr_pulse || st == IDLE || wrap)
        presc <= '0;
      else if (running)
        presc <= presc + PW'(1);
    end
  end

  assign sw.tick           = tick_r;
  assign sw.clear_count    = clear_count_r;
  assign sw.freeze_display = freeze_r;
  assign sw.state          = st;
endmodule
